// File: rtl/ps2_scancode_rx_if.sv
// Output bus of the PS/2 scancode receiver.
// Handshake: an entry {ext, release_flag, code} is transferred on every
// cycle where valid=1 and ready=1. In the strobe build, valid is a single
// cycle pulse and ready is ignored. err and ovf are one-cycle pulses that
// do not take part in the handshake.
// "release" is a reserved word, so the break flag is named release_flag.
interface ps2_scancode_rx_if;
  logic [7:0] code;
  logic       ext;
  logic       release_flag;
  logic       valid;
  logic       ready;
  logic       err;
  logic       ovf;

  modport master (
    output code, ext, release_flag, valid, err, ovf,
    input  ready
  );

  modport slave (
    input  code, ext, release_flag, valid, err, ovf,
    output ready
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: synchronises and filters the raw PS/2
// clock/data, deframes 11-bit frames, strips E0/F0 prefixes and emits the
// code with ext/release flags.
// Optional macro PS2_RX_FIFO_EN adds a 4-entry output FIFO with ready
// backpressure; without it valid is a one-cycle strobe.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 60000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ps2_kbd_clk,
  input  logic              ps2_kbd_data,
  ps2_scancode_rx_if.master bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          data_filt;
  logic [3:0]    clk_cnt;
  logic [3:0]    data_cnt;
  logic          clk_filt_q;
  logic          fall;

  state_t        state;
  state_t        state_next;
  logic          shift_en;
  logic          check_en;
  logic          to_run;

  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          frame_ok;

  logic          ext_pend;
  logic          rel_pend;
  logic          err_q;
  logic          emit_q;
  logic [7:0]    emit_code;
  logic          emit_ext;
  logic          emit_rel;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_kbd_clk};
      data_sync <= {data_sync[0], ps2_kbd_data};
    end
  end

  // Clock filter: flip only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      clk_cnt  <= 4'd0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_cnt <= 4'd0;
    end else if (clk_cnt == FL_LAST) begin
      clk_filt <= clk_sync[1];
      clk_cnt  <= 4'd0;
    end else begin
      clk_cnt <= clk_cnt + 4'd1;
    end
  end

  // Data filter, same rule as the clock filter.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      data_filt <= 1'b1;
      data_cnt  <= 4'd0;
    end else if (data_sync[1] == data_filt) begin
      data_cnt <= 4'd0;
    end else if (data_cnt == FL_LAST) begin
      data_filt <= data_sync[1];
      data_cnt  <= 4'd0;
    end else begin
      data_cnt <= data_cnt + 4'd1;
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) clk_filt_q <= 1'b1;
    else          clk_filt_q <= clk_filt;
  end

  assign fall = clk_filt_q & ~clk_filt;

  // Frame FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fall && !data_filt) state_next = SHIFT;
      end
      SHIFT: begin
        if (fall && bit_cnt == 4'd9)       state_next = CHECK;
        else if (!fall && to_cnt == TO_MAX) state_next = IDLE;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame FSM outputs.
  always_comb begin
    shift_en = 1'b0;
    check_en = 1'b0;
    to_run   = 1'b0;
    case (state)
      SHIFT: begin
        shift_en = fall;
        to_run   = 1'b1;
      end
      CHECK:   check_en = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Bit collection (LSB first into shreg[9:0] = {stop, parity, data}) and
  // the inter-edge timeout counter, which is zero outside SHIFT.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bit_cnt <= 4'd0;
      shreg   <= 10'd0;
      to_cnt  <= '0;
    end else begin
      if (state != SHIFT)  bit_cnt <= 4'd0;
      else if (shift_en)   bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) shreg <= {data_filt, shreg[9:1]};

      if (!to_run || fall)     to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
    end
  end

  assign frame_ok = shreg[9] & (^shreg[8:0]);

  // Frame check, prefix tracking and emission one cycle after CHECK.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ext_pend  <= 1'b0;
      rel_pend  <= 1'b0;
      err_q     <= 1'b0;
      emit_q    <= 1'b0;
      emit_code <= 8'h00;
      emit_ext  <= 1'b0;
      emit_rel  <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      emit_q <= 1'b0;
      if (check_en) begin
        if (!frame_ok) begin
          err_q    <= 1'b1;
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end else if (shreg[7:0] == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg[7:0] == 8'hF0) begin
          rel_pend <= 1'b1;
        end else begin
          emit_q    <= 1'b1;
          emit_code <= shreg[7:0];
          emit_ext  <= ext_pend;
          emit_rel  <= rel_pend;
          ext_pend  <= 1'b0;
          rel_pend  <= 1'b0;
        end
      end
    end
  end

  assign bus.err = err_q;

`ifdef PS2_RX_FIFO_EN
  logic [9:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_ok;
  logic       ovf_q;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign pop     = !empty && bus.ready;
  assign push_ok = emit_q && (!full || pop);

  // Output FIFO; a push into a full FIFO is only accepted alongside a pop.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 10'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {emit_ext, emit_rel, emit_code};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
      ovf_q <= emit_q && full && !pop;
    end
  end

  assign bus.valid        = !empty;
  assign bus.ext          = mem[rd_ptr][9];
  assign bus.release_flag = mem[rd_ptr][8];
  assign bus.code         = mem[rd_ptr][7:0];
  assign bus.ovf          = ovf_q;
`else
  logic unused_ready;

  assign unused_ready     = bus.ready;
  assign bus.valid        = emit_q;
  assign bus.ext          = emit_ext;
  assign bus.release_flag = emit_rel;
  assign bus.code         = emit_code;
  assign bus.ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames with a scoreboard queue
// of expected {ext, release, code} entries.
module tb_ps2_scancode_rx;
  localparam int HALF = 40;

  // Clock and reset
  logic       clk_sys      = 1'b0;
  logic       reset_n      = 1'b0;
  logic       ps2_kbd_clk  = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk_sys = ~clk_sys;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(
    .FILTER_LEN(2),
    .TIMEOUT   (200)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  // Scoreboard
  logic [9:0] exp_q[$];
  int         total    = 0;
  int         bad      = 0;
  int         err_seen = 0;
  int         ovf_seen = 0;
  logic [9:0] mon_e;
  logic       mon_have;
  logic       left_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: count pulses, pop and compare every transferred entry.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (bus.err) err_seen++;
      if (bus.ovf) ovf_seen++;
      if (bus.valid && bus.ready) begin
        mon_have = (exp_q.size() != 0);
        mon_e    = mon_have ? exp_q.pop_front() : 10'h000;
        check("emit", {1'b1, bus.ext, bus.release_flag, bus.code}, {mon_have, mon_e});
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_kbd_data = b;
    tick(HALF / 2);
    ps2_kbd_clk = 1'b0;
    tick(HALF);
    ps2_kbd_clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    tick(20);
  endtask

  initial begin
    bus.ready = 1'b1;

    // Reset values
    reset_n = 1'b0;
    tick(5);
    check("rst_code",  bus.code, 8'h00);
    check("rst_ext",   bus.ext, 1'b0);
    check("rst_rel",   bus.release_flag, 1'b0);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_err",   bus.err, 1'b0);
    check("rst_ovf",   bus.ovf, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    reset_n = 1'b1;
    tick(5);

    // Plain code
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    check("plain_1c_done", exp_q.size(), 0);
    check("plain_1c_err", err_seen, 0);

    // Extended break, then the same code with no prefixes
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("e0f0_75_done", exp_q.size(), 0);
    exp_q.push_back({2'b00, 8'h75});
    send_frame(8'h75, 1'b0);
    check("plain_75_done", exp_q.size(), 0);

    // Parity error clears the pending E0
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("parity_err", err_seen, 1);
    exp_q.push_back({2'b01, 8'h1C});
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("after_err_done", exp_q.size(), 0);

    // Partial frame abandoned by timeout
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(250);
    check("timeout_idle", dbg_state, 2'd0);
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0);
    check("timeout_29_done", exp_q.size(), 0);
    check("timeout_no_err", err_seen, 1);

    // One-cycle glitch on the clock line in IDLE
    left_idle   = 1'b0;
    ps2_kbd_clk = 1'b0;
    tick(1);
    ps2_kbd_clk = 1'b1;
    repeat (10) begin
      @(negedge clk_sys);
      if (dbg_state != 2'd0) left_idle = 1'b1;
    end
    tick(1);
    check("glitch_idle", left_idle, 1'b0);

    // Reset mid-frame abandons the frame and pending prefixes
    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("midrst_state", dbg_state, 2'd0);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    check("midrst_1c_done", exp_q.size(), 0);
    check("midrst_err", err_seen, 1);

`ifdef PS2_RX_FIFO_EN
    // FIFO fill with backpressure, overflow on the fifth code, then drain
    bus.ready = 1'b0;
    tick(2);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({2'b00, 8'(i * 8'h11)});
      send_frame(8'(i * 8'h11), 1'b0);
    end
    tick(5);
    check("fifo_ovf", ovf_seen, 1);
    check("fifo_full_valid", bus.valid, 1'b1);
    check("fifo_held", exp_q.size(), 4);
    bus.ready = 1'b1;
    tick(10);
    check("fifo_drained", exp_q.size(), 0);
    check("fifo_empty_valid", bus.valid, 1'b0);
`else
    check("no_ovf", ovf_seen, 0);
`endif

    // Final report
    tick(20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
